// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised sequence detector.
package seq_det_pkg;

    // Output style selectors for the MOORE parameter
    localparam int unsigned MODE_MEALY = 0;
    localparam int unsigned MODE_MOORE = 1;

    // Longest supported pattern and the packed transition-table geometry
    localparam int          LEN_MAX  = 16;
    localparam int unsigned TBL_W    = 4;
    localparam int unsigned TBL_BITS = 2 * 16 * TBL_W;

    // Bit of the pattern at stream position pos (position 0 is received first)
    function automatic logic pat_bit(input logic [15:0] pattern, input int len, input int pos);
        return pattern[4'(len - 1 - pos)];
    endfunction

    // KMP transition: longest proper prefix of the pattern that is a suffix of
    // (first k pattern bits followed by b). Capped below len, so a full match
    // collapses to the border length.
    function automatic int next_k(input logic [15:0] pattern, input int len,
                                  input int k, input logic b);
        int   best;
        int   q;
        logic ok;
        logic sb;
        best = 0;
        for (int j = 1; j < LEN_MAX; j++) begin
            if (j < len && j <= k + 1) begin
                ok = 1'b1;
                for (int p = 0; p < LEN_MAX; p++) begin
                    if (p < j) begin
                        q  = k + 1 - j + p;
                        sb = (q == k) ? b : pat_bit(pattern, len, q);
                        if (pat_bit(pattern, len, p) != sb) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return best;
    endfunction

    // Longest proper prefix of the pattern that is also its suffix
    function automatic int border(input logic [15:0] pattern, input int len);
        int   best;
        logic ok;
        best = 0;
        for (int j = 1; j < LEN_MAX; j++) begin
            if (j < len) begin
                ok = 1'b1;
                for (int p = 0; p < LEN_MAX; p++) begin
                    if (p < j && pat_bit(pattern, len, p) != pat_bit(pattern, len, len - j + p)) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return best;
    endfunction

    // Flattened next-state table indexed by {k, bit}, TBL_W bits per entry
    function automatic logic [TBL_BITS-1:0] build_next_table(input logic [15:0] pattern,
                                                            input int len);
        logic [TBL_BITS-1:0] tbl;
        tbl = '0;
        for (int k = 0; k < LEN_MAX; k++) begin
            for (int b = 0; b < 2; b++) begin
                if (k < len) begin
                    tbl[(k * 2 + b) * 4 +: 4] = 4'(next_k(pattern, len, k, 1'(b)));
                end
            end
        end
        return tbl;
    endfunction

endpackage

// File: rtl/seq_det_match_counter.sv
// Saturating match counter; reset beats clear, clear beats increment.
module seq_det_match_counter
    import seq_det_pkg::*;
#(
    parameter int unsigned CNT_W = 8
)(
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;

    // Count matches, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with KMP fallback, selectable
// overlap and Mealy/Moore output, plus a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned SEQ_LEN = 5,
    parameter logic [15:0] PATTERN = 16'b11011,
    parameter int unsigned OVERLAP = 0,
    parameter int unsigned MOORE   = MODE_MEALY,
    parameter int unsigned CNT_W   = 8
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       in,
    input  logic                       clr_cnt,
    output logic                       out,
    output logic [CNT_W-1:0]           match_count,
    output logic [$clog2(SEQ_LEN)-1:0] progress
);

    localparam int unsigned         KW       = $clog2(SEQ_LEN);
    localparam logic [KW-1:0]       K_LAST   = KW'(SEQ_LEN - 1);
    localparam logic [KW-1:0]       K_BORDER = KW'(border(PATTERN, int'(SEQ_LEN)));
    localparam logic [TBL_BITS-1:0] NEXT_TBL = build_next_table(PATTERN, int'(SEQ_LEN));
    localparam logic                PAT_LAST = PATTERN[0];

    // Reject illegal configurations at elaboration
    if (SEQ_LEN < 2 || SEQ_LEN > 16) begin : g_bad_len
        $error("seq_detector_param: SEQ_LEN must be in 2..16");
    end
    if ((PATTERN >> SEQ_LEN) != 16'd0) begin : g_bad_pattern
        $error("seq_detector_param: PATTERN is wider than SEQ_LEN");
    end

    logic [KW-1:0] r_k;
    logic [KW-1:0] w_k_next;
    logic          w_match;
    logic [6:0]    w_tbl_idx;
    logic [3:0]    w_tbl_k;

    // Match detect and next matched-prefix length
    always_comb begin
        w_match   = 1'b0;
        w_k_next  = r_k;
        w_tbl_idx = 7'({4'(r_k), in}) << 2;
        w_tbl_k   = NEXT_TBL[w_tbl_idx +: 4];
        if (en) begin
            w_match = (r_k == K_LAST) && (in == PAT_LAST);
            if (w_match) begin
                w_k_next = (OVERLAP != 0) ? K_BORDER : '0;
            end else begin
                w_k_next = KW'(w_tbl_k);
            end
        end
    end

    // Matched-prefix length register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k <= '0;
        end else begin
            r_k <= w_k_next;
        end
    end

    assign progress = r_k;

    if (MOORE == MODE_MOORE) begin : g_moore
        logic r_out;

        // Registered detect flag, high the cycle after the final bit
        always_ff @(posedge clk) begin
            if (rst) begin
                r_out <= 1'b0;
            end else begin
                r_out <= w_match;
            end
        end

        assign out = r_out;
    end else begin : g_mealy
        // Same-cycle detect, suppressed while in reset
        assign out = w_match & ~rst;
    end

    seq_det_match_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk     (clk),
        .i_rst   (rst),
        .i_inc   (w_match),
        .i_clr   (clr_cnt),
        .o_count (match_count)
    );

endmodule
